cache_port_requester: RTL

CACHE_PORT_REQUESTER -- requirements
Module: cache_port_requester

---
 rtl/cache_port_requester_pkg.sv | 13 +
 rtl/cache_port_requester_fifo.sv | 38 +++
 rtl/cache_port_requester.sv | 92 +++++++++
 3 files changed

// File: rtl/cache_port_requester_pkg.sv
// cache_port_requester_pkg: shared widths, FSM state encoding and queued-request entry layout
package cache_port_requester_pkg;
  localparam int CACHE_BANK_ADDRESS_WIDTH = 8;
  localparam int NETWORK_ADDRESS_WIDTH = 4;
  localparam int DATA_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
  typedef struct packed {
    logic write;
    logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddress;
    logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddress;
    logic [DATA_WIDTH-1:0] data;
  } reqEntry_t;
endpackage

// File: rtl/cache_port_requester_fifo.sv
// request_fifo: DEPTH-entry request queue (clk, reset, push/pushData in, pop in, popData=head out, full/empty out)
module request_fifo
  import cache_port_requester_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  reqEntry_t pushData,
  output reqEntry_t popData,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  reqEntry_t mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic doPush, doPop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign popData = mem[rdPtr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(doPush);
      rdPtr <= rdPtr + AW'(doPop);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= pushData;
endmodule

// File: rtl/cache_port_requester.sv
// cache_port_requester: queues client requests, issues them one at a time to an arbiter port (memRead/memWrite until a tag-matched readReady), reports respValid or timeoutError
module cache_port_requester
  import cache_port_requester_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                reqValid,
  output logic                                reqReady,
  input  logic                                reqWrite,
  input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] reqCacheAddress,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    reqRequesterAddress,
  input  logic [DATA_WIDTH-1:0]               reqData,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut,
  output logic                                memRead,
  output logic                                memWrite,
  output logic [DATA_WIDTH-1:0]               dataOut,
  input  logic                                readReady,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn,
  input  logic [DATA_WIDTH-1:0]               cacheDataIn,
  output logic                                respValid,
  output logic                                respWrite,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    respRequesterAddress,
  output logic [DATA_WIDTH-1:0]               respData,
  output logic                                timeoutError
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  reqEntry_t head;
  logic full, empty, pop, complete, heldWrite;
  logic [CW-1:0] cnt;
  assign reqReady = !full;
  assign pop = !empty && (state == IDLE || state == RESPOND);
  assign complete = state == ISSUE && readReady && requesterAddressIn == requesterAddressOut;
  assign timeoutError = state == ISSUE && !complete && cnt == CW'(TIMEOUT_CYCLES - 1);
  request_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(reqValid),
    .pop(pop),
    .pushData('{reqWrite, reqCacheAddress, reqRequesterAddress, reqData}),
    .popData(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      heldWrite <= 1'b0;
      cacheAddressOut <= '0;
      requesterAddressOut <= '0;
      dataOut <= '0;
      memRead <= 1'b0;
      memWrite <= 1'b0;
      respValid <= 1'b0;
      respWrite <= 1'b0;
      respRequesterAddress <= '0;
      respData <= '0;
    end else begin
      respValid <= 1'b0;
      if (pop) begin
        state <= ISSUE;
        cnt <= '0;
        heldWrite <= head.write;
        cacheAddressOut <= head.cacheAddress;
        requesterAddressOut <= head.requesterAddress;
        dataOut <= head.data;
        memRead <= !head.write;
        memWrite <= head.write;
      end else if (state == RESPOND) begin
        state <= IDLE;
      end else if (complete) begin
        state <= RESPOND;
        memRead <= 1'b0;
        memWrite <= 1'b0;
        respValid <= 1'b1;
        respWrite <= heldWrite;
        respRequesterAddress <= requesterAddressOut;
        respData <= heldWrite ? '0 : cacheDataIn;
      end else if (timeoutError) begin
        state <= IDLE;
        memRead <= 1'b0;
        memWrite <= 1'b0;
      end else if (state == ISSUE) begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule
